// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a valid/ready FIFO
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int CLK_HZ     = 10000,
  parameter int BAUD       = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head, shreg;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic                 par, tick, last_stop, push, pop;
  always_comb begin
    head      = mem[rd_ptr];
    tick      = cnt == CW'(DIV - 1);
    last_stop = idx == BW'(STOP_BITS - 1);
    in_ready  = fifo_count != (AW+1)'(FIFO_DEPTH);
    push      = in_valid && in_ready;
    pop       = fifo_count != '0 && (state == IDLE || (state == STOP && tick && last_stop));
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  // A pop always starts a frame, so it overrides the per-state bit sequencing.
  always_ff @(posedge clk)
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      cnt        <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      tx_done    <= state == STOP && last_stop && cnt == CW'(DIV - 2);
      if (pop) begin
        state <= START;
        shreg <= head;
        par   <= (^head) ^ (PARITY == 2);
        idx   <= '0;
        tx    <= 1'b0;
        busy  <= 1'b1;
      end else
        case (state)
          IDLE: ;
          START:
            if (tick) begin
              state <= DATA;
              idx   <= '0;
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          DATA:
            if (tick) begin
              if (idx == BW'(DATA_BITS - 1)) begin
                state <= PARITY != 0 ? PAR : STOP;
                idx   <= '0;
                tx    <= PARITY != 0 ? par : 1'b1;
              end else begin
                idx   <= idx + BW'(1);
                tx    <= shreg[0];
                shreg <= shreg >> 1;
              end
            end
          PAR:
            if (tick) begin
              state <= STOP;
              idx   <= '0;
              tx    <= 1'b1;
            end
          STOP:
            if (tick) begin
              if (last_stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                tx    <= 1'b1;
              end else
                idx <= idx + BW'(1);
            end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            tx    <= 1'b1;
          end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo in three configurations
module tb_uart_tx_fifo;
  logic       clk, reset;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       v0, v1, v2;
  logic       r0, r1, r2, t0, t1, t2, b0, b1, b2, x0, x1, x2;
  logic [2:0] c0, c1, c2;
  int         tests, fails, sel;
  logic       tx_m, busy_m, done_m, ready_m;
  logic [2:0] count_m;
  logic       txs [400];
  logic       bsy [400];
  logic       dn [400];
  logic       rdy [400];
  logic [2:0] cnt_s [400];

  uart_tx_fifo dut0 (.clk(clk), .reset(reset), .in_data(d0), .in_valid(v0), .in_ready(r0),
    .tx(t0), .busy(b0), .tx_done(x0), .fifo_count(c0));
  uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) dut1 (.clk(clk), .reset(reset), .in_data(d1),
    .in_valid(v1), .in_ready(r1), .tx(t1), .busy(b1), .tx_done(x1), .fifo_count(c1));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(0)) dut2 (.clk(clk), .reset(reset), .in_data(d2),
    .in_valid(v2), .in_ready(r2), .tx(t2), .busy(b2), .tx_done(x2), .fifo_count(c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    tx_m    = sel == 1 ? t1 : sel == 2 ? t2 : t0;
    busy_m  = sel == 1 ? b1 : sel == 2 ? b2 : b0;
    done_m  = sel == 1 ? x1 : sel == 2 ? x2 : x0;
    ready_m = sel == 1 ? r1 : sel == 2 ? r2 : r0;
    count_m = sel == 1 ? c1 : sel == 2 ? c2 : c0;
  end

  task automatic record(int n, bit scramble);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      txs[j]   = tx_m;
      bsy[j]   = busy_m;
      dn[j]    = done_m;
      rdy[j]   = ready_m;
      cnt_s[j] = count_m;
      if (scramble) d0 = 8'($urandom);
    end
  endtask

  function automatic logic [15:0] frame_bits(int nb);
    logic [15:0] f = '0;
    for (int k = 0; k < nb; k++) f[k] = txs[10*k+5];
    return f;
  endfunction

  function automatic int glitches(int nb);
    int g = 0;
    for (int k = 0; k < nb; k++)
      for (int c = 0; c < 10; c++) if (txs[10*k+c] !== txs[10*k]) g++;
    return g;
  endfunction

  function automatic int busy_count(int n);
    int s = 0;
    for (int j = 0; j < n; j++) if (bsy[j] === 1'b1) s++;
    return s;
  endfunction

  function automatic int done_count(int n);
    int s = 0;
    for (int j = 0; j < n; j++) if (dn[j] === 1'b1) s++;
    return s;
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    tests++; if (t0 !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", t0); end
    tests++; if (b0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", b0); end
    tests++; if (x0 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", x0); end
    tests++; if (c0 !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", c0); end
    tests++; if (r0 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", r0); end
    tests++; if ({t1, t2} !== 2'b11) begin fails++; $display("FAIL reset_tx_others: got %b want 11", {t1, t2}); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if ({t0, b0} !== 2'b10) begin fails++; $display("FAIL idle_after_reset: got %b want 10", {t0, b0}); end
  endtask

  task automatic test_frame_a5;
    sel = 0;
    d0 = 8'hA5; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    tests++; if (c0 !== 3'd1) begin fails++; $display("FAIL a5_count_after_push: got %0d want 1", c0); end
    tests++; if (t0 !== 1'b1) begin fails++; $display("FAIL a5_tx_before_start: got %b want 1", t0); end
    record(112, 1'b0);
    tests++; if (frame_bits(11) !== 16'h054A) begin fails++; $display("FAIL a5_frame: got %h want 054a", frame_bits(11)); end
    tests++; if (glitches(11) !== 0) begin fails++; $display("FAIL a5_bit_width: got %0d unstable samples want 0", glitches(11)); end
    tests++; if (busy_count(112) !== 110) begin fails++; $display("FAIL a5_busy_len: got %0d want 110", busy_count(112)); end
    tests++; if (done_count(112) !== 1) begin fails++; $display("FAIL a5_done_pulses: got %0d want 1", done_count(112)); end
    tests++; if (dn[109] !== 1'b1) begin fails++; $display("FAIL a5_done_pos: got %b want 1", dn[109]); end
    tests++; if ({txs[110], bsy[110]} !== 2'b10) begin fails++; $display("FAIL a5_idle_after: got %b want 10", {txs[110], bsy[110]}); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w1, w2;
    logic [2:0] exp_c [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    sel = 0;
    d0 = 8'h11; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    tests++; if (c0 !== 3'd1) begin fails++; $display("FAIL b2b_first_push: got %0d want 1", c0); end
    for (int j = 0; j < 225; j++) begin
      @(negedge clk);
      txs[j]   = t0;
      dn[j]    = x0;
      rdy[j]   = r0;
      cnt_s[j] = c0;
      v0 = j < 111;
      d0 = j < 4 ? 8'(8'h22 + 8'h11 * j) : 8'h66;
    end
    v0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tests++; if (cnt_s[k] !== exp_c[k]) begin fails++; $display("FAIL b2b_fill_%0d: got %0d want %0d", k, cnt_s[k], exp_c[k]); end
    end
    tests++; if (rdy[4] !== 1'b0) begin fails++; $display("FAIL b2b_ready_full: got %b want 0", rdy[4]); end
    tests++; if (rdy[109] !== 1'b0) begin fails++; $display("FAIL b2b_ready_held: got %b want 0", rdy[109]); end
    tests++; if (rdy[110] !== 1'b1) begin fails++; $display("FAIL b2b_ready_after_pop: got %b want 1", rdy[110]); end
    tests++; if (cnt_s[110] !== 3'd3) begin fails++; $display("FAIL b2b_pop_count: got %0d want 3", cnt_s[110]); end
    tests++; if (cnt_s[111] !== 3'd4) begin fails++; $display("FAIL b2b_late_push: got %0d want 4", cnt_s[111]); end
    tests++; if ({txs[109], txs[110]} !== 2'b10) begin fails++; $display("FAIL b2b_no_gap: got %b want 10", {txs[109], txs[110]}); end
    tests++; if ({dn[109], dn[219]} !== 2'b11) begin fails++; $display("FAIL b2b_done: got %b want 11", {dn[109], dn[219]}); end
    tests++; if (cnt_s[220] !== 3'd3) begin fails++; $display("FAIL b2b_third_pop: got %0d want 3", cnt_s[220]); end
    for (int i = 0; i < 8; i++) begin
      w1[i] = txs[15+10*i];
      w2[i] = txs[125+10*i];
    end
    tests++; if (w1 !== 8'h11) begin fails++; $display("FAIL b2b_word1: got %h want 11", w1); end
    tests++; if (w2 !== 8'h22) begin fails++; $display("FAIL b2b_word2: got %h want 22", w2); end
  endtask

  task automatic test_reset_mid_frame;
    int lows;
    sel = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    d0 = 8'h01; v0 = 1'b1;
    @(negedge clk);
    d0 = 8'h02;
    @(negedge clk);
    d0 = 8'h03;
    @(negedge clk);
    v0 = 1'b0;
    repeat (33) @(negedge clk);
    tests++; if ({b0, c0} !== 4'b1010) begin fails++; $display("FAIL mid_pre_state: got busy=%b count=%0d want busy=1 count=2", b0, c0); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tests++; if ({t0, b0, x0, r0} !== 4'b1001) begin fails++; $display("FAIL mid_reset_outs: got %b want 1001", {t0, b0, x0, r0}); end
    tests++; if (c0 !== 3'd0) begin fails++; $display("FAIL mid_reset_count: got %0d want 0", c0); end
    record(40, 1'b0);
    lows = 0;
    for (int j = 0; j < 40; j++) if (txs[j] !== 1'b1) lows++;
    tests++; if (lows !== 0) begin fails++; $display("FAIL mid_line_quiet: got %0d low samples want 0", lows); end
    tests++; if (busy_count(40) + done_count(40) !== 0) begin fails++; $display("FAIL mid_no_activity: got %0d want 0", busy_count(40) + done_count(40)); end
    d0 = 8'hA5; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    record(112, 1'b0);
    tests++; if (frame_bits(11) !== 16'h054A) begin fails++; $display("FAIL mid_recover_frame: got %h want 054a", frame_bits(11)); end
    tests++; if (done_count(112) !== 1) begin fails++; $display("FAIL mid_recover_done: got %0d want 1", done_count(112)); end
  endtask

  task automatic test_capture;
    sel = 0;
    d0 = 8'h3C; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    d0 = 8'hFF;
    record(112, 1'b1);
    tests++; if (frame_bits(11) !== 16'h0478) begin fails++; $display("FAIL capture_frame: got %h want 0478", frame_bits(11)); end
    tests++; if (glitches(11) !== 0) begin fails++; $display("FAIL capture_stable: got %0d unstable samples want 0", glitches(11)); end
  endtask

  task automatic test_odd_two_stop;
    sel = 1;
    d1 = 8'h00; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    tests++; if ({c1, t1} !== 4'b0011) begin fails++; $display("FAIL odd_push: got count=%0d tx=%b want 1,1", c1, t1); end
    record(122, 1'b0);
    tests++; if (frame_bits(12) !== 16'h0E00) begin fails++; $display("FAIL odd_frame: got %h want 0e00", frame_bits(12)); end
    tests++; if (glitches(12) !== 0) begin fails++; $display("FAIL odd_bit_width: got %0d want 0", glitches(12)); end
    tests++; if (busy_count(122) !== 120) begin fails++; $display("FAIL odd_busy_len: got %0d want 120", busy_count(122)); end
    tests++; if ({dn[119], done_count(122) == 1} !== 2'b11) begin fails++; $display("FAIL odd_done: got pos=%b cnt=%0d want 1,1", dn[119], done_count(122)); end
  endtask

  task automatic test_seven_no_parity;
    sel = 2;
    d2 = 7'h55; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    record(92, 1'b0);
    tests++; if (frame_bits(9) !== 16'h01AA) begin fails++; $display("FAIL seven_frame: got %h want 01aa", frame_bits(9)); end
    tests++; if (glitches(9) !== 0) begin fails++; $display("FAIL seven_bit_width: got %0d want 0", glitches(9)); end
    tests++; if (busy_count(92) !== 90) begin fails++; $display("FAIL seven_busy_len: got %0d want 90", busy_count(92)); end
    tests++; if ({dn[89], done_count(92) == 1} !== 2'b11) begin fails++; $display("FAIL seven_done: got pos=%b cnt=%0d want 1,1", dn[89], done_count(92)); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    sel = 0;
    test_reset;
    test_frame_a5;
    test_back_to_back;
    test_reset_mid_frame;
    test_capture;
    test_odd_two_stop;
    test_seven_no_parity;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
